// File: rtl/ei_axi4_slave_pkg.sv
// Shared types for the AXI4 slave memory: burst encodings, response codes
// and the write/read channel state machines.
package ei_axi4_slave_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/ei_axi4_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
module ei_axi4_addr_gen
  import ei_axi4_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [7:0]            i_len,
  input  logic [2:0]            i_size,
  input  logic [1:0]            i_burst,
  output logic [ADDR_WIDTH-1:0] o_next
);

  logic [ADDR_WIDTH-1:0] w_step;
  logic [ADDR_WIDTH-1:0] w_wrap_bytes;
  logic [ADDR_WIDTH-1:0] w_wrap_mask;
  logic [ADDR_WIDTH-1:0] w_incr;

  assign w_step       = ADDR_WIDTH'(1) << i_size;
  assign w_wrap_bytes = ADDR_WIDTH'({1'b0, i_len} + 9'd1) << i_size;
  assign w_wrap_mask  = w_wrap_bytes - ADDR_WIDTH'(1);
  assign w_incr       = i_addr + w_step;

  // WRAP keeps the window base and lets only the in-window offset advance.
  always_comb begin
    case (i_burst)
      BURST_FIXED: o_next = i_addr;
      BURST_WRAP:  o_next = (i_addr & ~w_wrap_mask) | (w_incr & w_wrap_mask);
      default:     o_next = w_incr;
    endcase
  end

endmodule

// File: rtl/ei_axi4_slave_mem.sv
// AXI4 slave backed by a byte-strobed word memory; independent single-burst
// write and read engines with SLVERR detection.
module ei_axi4_slave_mem
  import ei_axi4_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LOG2B = $clog2(BYTES);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int EW    = ADDR_WIDTH + 17;
  localparam logic [EW-1:0] LIMIT = EW'(MEM_DEPTH) * EW'(BYTES);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  function automatic logic hdr_err(input logic [7:0] len, input logic [2:0] size,
                                   input logic [1:0] burst);
    return (burst == BURST_RSVD) || (size > 3'(LOG2B)) ||
           ((burst == BURST_WRAP) && !wrap_len_ok(len));
  endfunction

  // Highest byte address any beat of the burst touches; INCR past the top of
  // the address space lands beyond LIMIT and is flagged as well.
  function automatic logic range_err(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
    logic [EW-1:0] a;
    logic [EW-1:0] wb;
    logic [EW-1:0] hi;
    a  = EW'(addr);
    wb = EW'({1'b0, len} + 9'd1) << size;
    case (burst)
      BURST_FIXED: hi = a;
      BURST_WRAP:  hi = (a & ~(wb - EW'(1))) + wb - EW'(1);
      default:     hi = a + (EW'(len) << size);
    endcase
    return hi >= LIMIT;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] w;
    w = a >> LOG2B;
    return IDX_W'(w % ADDR_WIDTH'(MEM_DEPTH));
  endfunction

  wstate_e               r_wstate, w_wstate_nxt;
  logic [ADDR_WIDTH-1:0] r_waddr, w_wnext;
  logic [7:0]            r_wlen, r_wbeat;
  logic [2:0]            r_wsize;
  logic [1:0]            r_wburst;
  logic                  r_werr;
  logic                  w_aw_hs, w_w_hs, w_wbeat_last, w_wlast_bad;
  logic [IDX_W-1:0]      w_widx;

  assign w_aw_hs      = awvalid & awready;
  assign w_w_hs       = wvalid & wready;
  assign w_wbeat_last = (r_wbeat == r_wlen);
  assign w_wlast_bad  = (wlast != w_wbeat_last);
  assign w_widx       = word_idx(r_waddr);

  ei_axi4_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_agen (
    .i_addr  (r_waddr),
    .i_len   (r_wlen),
    .i_size  (r_wsize),
    .i_burst (r_wburst),
    .o_next  (w_wnext)
  );

  always_comb begin
    w_wstate_nxt = r_wstate;
    awready      = 1'b0;
    wready       = 1'b0;
    bvalid       = 1'b0;
    bresp        = RESP_OKAY;
    case (r_wstate)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) w_wstate_nxt = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && w_wbeat_last) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        bresp  = r_werr ? RESP_SLVERR : RESP_OKAY;
        if (bready) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) r_wstate <= W_IDLE;
    else        r_wstate <= w_wstate_nxt;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wbeat <= 8'd0;
      r_werr  <= 1'b0;
    end else if (w_aw_hs) begin
      r_wbeat <= 8'd0;
      r_werr  <= hdr_err(awlen, awsize, awburst) || range_err(awaddr, awlen, awsize, awburst);
    end else if (w_w_hs) begin
      r_wbeat <= r_wbeat + 8'd1;
      if (w_wlast_bad) r_werr <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (w_aw_hs) begin
      r_waddr  <= awaddr;
      r_wlen   <= awlen;
      r_wsize  <= awsize;
      r_wburst <= awburst;
    end else if (w_w_hs) begin
      r_waddr <= w_wnext;
    end
  end

  // Range and header errors are known at AW time, so an erroneous burst never
  // touches memory; a wlast misplacement blocks writes from that beat on.
  always_ff @(posedge aclk) begin
    if (w_w_hs && !r_werr && !w_wlast_bad && !areset) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb[b]) r_mem[w_widx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  rstate_e               r_rstate, w_rstate_nxt;
  logic [ADDR_WIDTH-1:0] r_raddr, w_rnext, w_rfetch_addr;
  logic [7:0]            r_rlen, r_rbeat;
  logic [2:0]            r_rsize;
  logic [1:0]            r_rburst;
  logic                  r_rberr;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic                  r_rlast;
  logic                  w_ar_hs, w_r_hs, w_rfetch_err;
  logic [IDX_W-1:0]      w_ridx;

  assign w_ar_hs       = arvalid & arready;
  assign w_r_hs        = rvalid & rready;
  assign w_rfetch_addr = (r_rstate == R_IDLE) ? araddr : w_rnext;
  assign w_rfetch_err  = ((r_rstate == R_IDLE) ? hdr_err(arlen, arsize, arburst) : r_rberr) ||
                         (EW'(w_rfetch_addr) >= LIMIT);
  assign w_ridx        = word_idx(w_rfetch_addr);

  ei_axi4_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_agen (
    .i_addr  (r_raddr),
    .i_len   (r_rlen),
    .i_size  (r_rsize),
    .i_burst (r_rburst),
    .o_next  (w_rnext)
  );

  always_comb begin
    w_rstate_nxt = r_rstate;
    arready      = 1'b0;
    rvalid       = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) w_rstate_nxt = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready && r_rlast) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) r_rstate <= R_IDLE;
    else        r_rstate <= w_rstate_nxt;
  end

  // Beat data is fetched one cycle ahead from the registered memory read, so
  // a same-cycle write to that word is not yet visible.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
      r_rlast <= 1'b0;
      r_rbeat <= 8'd0;
      r_rberr <= 1'b0;
    end else if (w_ar_hs) begin
      r_rdata <= w_rfetch_err ? '0 : r_mem[w_ridx];
      r_rresp <= w_rfetch_err ? RESP_SLVERR : RESP_OKAY;
      r_rlast <= (arlen == 8'd0);
      r_rbeat <= 8'd0;
      r_rberr <= hdr_err(arlen, arsize, arburst);
    end else if (w_r_hs) begin
      if (r_rlast) begin
        r_rlast <= 1'b0;
      end else begin
        r_rdata <= w_rfetch_err ? '0 : r_mem[w_ridx];
        r_rresp <= w_rfetch_err ? RESP_SLVERR : RESP_OKAY;
        r_rlast <= ((r_rbeat + 8'd1) == r_rlen);
        r_rbeat <= r_rbeat + 8'd1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (w_ar_hs) begin
      r_raddr  <= araddr;
      r_rlen   <= arlen;
      r_rsize  <= arsize;
      r_rburst <= arburst;
    end else if (w_r_hs && !r_rlast) begin
      r_raddr <= w_rnext;
    end
  end

  assign rdata = r_rdata;
  assign rresp = r_rresp;
  assign rlast = r_rlast;

endmodule

// File: tb/tb_ei_axi4_slave_mem.sv
// Directed bench for ei_axi4_slave_mem: bursts, stalls, errors, reset.
module tb_ei_axi4_slave_mem;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst;
  logic        awvalid, awready, arvalid, arready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, rlast, rvalid, rready;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] wbuf [16];
  logic [31:0] rbuf [16];
  logic [1:0]  rrsp [16];
  logic        rlst [16];

  always #5 aclk = ~aclk;

  ei_axi4_slave_mem dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] strb, input int lastpos,
                           output logic [1:0] resp, output int nb);
    int cnt;
    awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    cnt = 0;
    while (!awready && cnt < 50) begin tick(); cnt++; end
    if (cnt >= 50) check_eq("aw_timeout", 0, 1);
    tick();
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wbuf[i]; wstrb = strb; wlast = (i == lastpos); wvalid = 1'b1;
      cnt = 0;
      while (!wready && cnt < 50) begin tick(); cnt++; end
      if (cnt >= 50) check_eq("w_timeout", 0, 1);
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    cnt = 0;
    while (!bvalid && cnt < 50) begin tick(); cnt++; end
    resp = bresp;
    nb = bvalid ? 1 : 0;
    tick();
    bready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (bvalid) nb++;
      tick();
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input int stall_beat, input int stall_cyc);
    int cnt, nbeats;
    logic [31:0] held;
    logic        held_l;
    araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    cnt = 0;
    while (!arready && cnt < 50) begin tick(); cnt++; end
    if (cnt >= 50) check_eq("ar_timeout", 0, 1);
    tick();
    arvalid = 1'b0;
    check_eq("rd_first_lat", rvalid, 1);
    rready = 1'b1;
    nbeats = 0; cnt = 0;
    while (nbeats <= int'(len) && cnt < 300) begin
      if (rvalid) begin
        if (nbeats == stall_beat && stall_cyc > 0) begin
          held = rdata; held_l = rlast; rready = 1'b0;
          for (int k = 0; k < stall_cyc; k++) begin
            tick();
            check_eq("stall_rvalid", rvalid, 1);
            check_eq("stall_rdata", rdata, held);
            check_eq("stall_rlast", rlast, held_l);
          end
          rready = 1'b1;
        end
        rbuf[nbeats] = rdata; rrsp[nbeats] = rresp; rlst[nbeats] = rlast;
        nbeats++;
      end
      tick();
      cnt++;
    end
    rready = 1'b0;
    check_eq("rd_beats", nbeats, int'(len) + 1);
    check_eq("rd_idle_after", rvalid, 0);
  endtask

  task automatic expect_beats(input string tag, input int n, input logic [31:0] d0,
                              input logic [31:0] d1, input logic [31:0] d2,
                              input logic [31:0] d3, input logic [1:0] rs);
    logic [31:0] exp_d [4];
    exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2; exp_d[3] = d3;
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_data"}, rbuf[i], exp_d[i]);
      check_eq({tag, "_resp"}, rrsp[i], rs);
      check_eq({tag, "_last"}, rlst[i], (i == n - 1));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [1:0] resp;
    int nb;
    areset = 1'b1;
    awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    tick();
    tick();
    check_eq("rst_awready", awready, 1);
    check_eq("rst_arready", arready, 1);
    check_eq("rst_wready", wready, 0);
    check_eq("rst_bvalid", bvalid, 0);
    check_eq("rst_rvalid", rvalid, 0);
    check_eq("rst_rlast", rlast, 0);
    check_eq("rst_bresp", bresp, 0);
    check_eq("rst_rresp", rresp, 0);
    check_eq("rst_rdata", rdata, 0);
    areset = 1'b0;
    tick();

    // INCR write of four words at 0x10, then readbacks
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + i;
    axi_write(32'h10, 8'd3, 3'd2, 2'b01, 4'hF, 3, resp, nb);
    check_eq("incr_wr_bresp", resp, 2'b00);
    check_eq("incr_wr_nb", nb, 1);
    axi_read(32'h10, 8'd3, 3'd2, 2'b01, -1, 0);
    expect_beats("incr_rd", 4, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 2'b00);

    // WRAP read starting mid-window: 0x18,0x1C,0x10,0x14
    axi_read(32'h18, 8'd3, 3'd2, 2'b10, -1, 0);
    expect_beats("wrap_rd", 4, 32'hA2, 32'hA3, 32'hA0, 32'hA1, 2'b00);

    // FIXED read repeats the same word
    axi_read(32'h14, 8'd2, 3'd2, 2'b00, -1, 0);
    expect_beats("fixed_rd", 3, 32'hA1, 32'hA1, 32'hA1, 32'h0, 2'b00);

    // Back-pressure on beat index 2 for five cycles
    axi_read(32'h10, 8'd3, 3'd2, 2'b01, 2, 5);
    expect_beats("stall_rd", 4, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 2'b00);

    // Out-of-range write must not alias onto word 0
    wbuf[0] = 32'h12345678;
    axi_write(32'h0, 8'd0, 3'd2, 2'b01, 4'hF, 0, resp, nb);
    check_eq("w0_bresp", resp, 2'b00);
    wbuf[0] = 32'hDEADBEEF;
    axi_write(32'd4096, 8'd0, 3'd2, 2'b01, 4'hF, 0, resp, nb);
    check_eq("oob_wr_bresp", resp, 2'b10);
    check_eq("oob_wr_nb", nb, 1);
    axi_read(32'h0, 8'd0, 3'd2, 2'b01, -1, 0);
    expect_beats("oob_unchanged", 1, 32'h12345678, 0, 0, 0, 2'b00);

    // Reserved burst read: both beats SLVERR with zero data
    axi_read(32'h0, 8'd1, 3'd2, 2'b11, -1, 0);
    expect_beats("rsvd_rd", 2, 32'h0, 32'h0, 0, 0, 2'b10);

    // Per-beat range error: last in-range word then first out-of-range
    axi_read(32'hFFC, 8'd1, 3'd2, 2'b01, -1, 0);
    check_eq("edge_rd_resp0", rrsp[0], 2'b00);
    check_eq("edge_rd_resp1", rrsp[1], 2'b10);
    check_eq("edge_rd_data1", rbuf[1], 32'h0);
    check_eq("edge_rd_last1", rlst[1], 1);

    // Partial strobe merges into existing word
    wbuf[0] = 32'hFFFFFFFF;
    axi_write(32'h0, 8'd0, 3'd2, 2'b01, 4'h3, 0, resp, nb);
    check_eq("strb_wr_bresp", resp, 2'b00);
    axi_read(32'h0, 8'd0, 3'd2, 2'b01, -1, 0);
    expect_beats("strb_rd", 1, 32'h1234FFFF, 0, 0, 0, 2'b00);

    // Oversized beat is rejected and leaves memory intact
    wbuf[0] = 32'h55;
    axi_write(32'h100, 8'd0, 3'd2, 2'b01, 4'hF, 0, resp, nb);
    wbuf[0] = 32'h66;
    axi_write(32'h100, 8'd0, 3'd3, 2'b01, 4'hF, 0, resp, nb);
    check_eq("size_wr_bresp", resp, 2'b10);
    axi_read(32'h100, 8'd0, 3'd2, 2'b01, -1, 0);
    expect_beats("size_unchanged", 1, 32'h55, 0, 0, 0, 2'b00);

    // Illegal WRAP length and misplaced wlast
    wbuf[0] = 32'h1; wbuf[1] = 32'h2; wbuf[2] = 32'h3;
    axi_write(32'h40, 8'd2, 3'd2, 2'b10, 4'hF, 2, resp, nb);
    check_eq("wraplen_wr_bresp", resp, 2'b10);
    axi_write(32'h40, 8'd1, 3'd2, 2'b01, 4'hF, 0, resp, nb);
    check_eq("early_wlast_bresp", resp, 2'b10);
    check_eq("early_wlast_nb", nb, 1);
    axi_write(32'h40, 8'd0, 3'd2, 2'b01, 4'hF, 9, resp, nb);
    check_eq("no_wlast_bresp", resp, 2'b10);

    // Same-cycle write and read of one word: read sees the old value
    wbuf[0] = 32'h11111111;
    axi_write(32'h20, 8'd0, 3'd2, 2'b01, 4'hF, 0, resp, nb);
    awaddr = 32'h20; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    check_eq("rw_awready", awready, 1);
    tick();
    awvalid = 1'b0;
    wdata = 32'h22222222; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    araddr = 32'h20; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    check_eq("rw_wready", wready, 1);
    check_eq("rw_arready", arready, 1);
    tick();
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    check_eq("rw_rvalid", rvalid, 1);
    check_eq("rw_old_data", rdata, 32'h11111111);
    rready = 1'b1; bready = 1'b1;
    check_eq("rw_bvalid", bvalid, 1);
    tick();
    rready = 1'b0; bready = 1'b0;
    axi_read(32'h20, 8'd0, 3'd2, 2'b01, -1, 0);
    expect_beats("rw_new_data", 1, 32'h22222222, 0, 0, 0, 2'b00);

    // Reset during beat 2 of an 8-beat write
    awaddr = 32'h80; awlen = 8'd7; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wdata = 32'hB0 + i; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
      check_eq("rst_burst_wready", wready, 1);
      tick();
    end
    wdata = 32'hB2; wvalid = 1'b1; areset = 1'b1;
    tick();
    areset = 1'b0; wvalid = 1'b0;
    check_eq("midrst_awready", awready, 1);
    check_eq("midrst_bvalid", bvalid, 0);
    check_eq("midrst_wready", wready, 0);
    tick();
    axi_read(32'h80, 8'd1, 3'd2, 2'b01, -1, 0);
    expect_beats("midrst_kept", 2, 32'hB0, 32'hB1, 0, 0, 2'b00);
    wbuf[0] = 32'hC0; wbuf[1] = 32'hC1;
    axi_write(32'h90, 8'd1, 3'd2, 2'b01, 4'hF, 1, resp, nb);
    check_eq("post_rst_bresp", resp, 2'b00);
    check_eq("post_rst_nb", nb, 1);
    axi_read(32'h90, 8'd1, 3'd2, 2'b01, -1, 0);
    expect_beats("post_rst_rd", 2, 32'hC0, 32'hC1, 0, 0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
